// File: rtl/alu_64.sv
// alu_64: 64-bit execute-stage ALU with registered result and flags.
// Ports: clk, reset (async, active-high), A/B operands, cntrl op select,
//        result, negative, zero, overflow, carry_out (all registered).
module alu_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    logic             sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic             sum_co;
    logic             sum_ov;

    logic [WIDTH-1:0] result_d, result_q;
    logic             neg_d, neg_q;
    logic             zero_d, zero_q;
    logic             ovf_d, ovf_q;
    logic             cout_d, cout_q;

    // Single shared adder: subtract is A + ~B + 1.
    assign sub  = (cntrl == OP_SUB);
    assign b_op = B ^ {WIDTH{sub}};

    assign {sum_co, sum} = {1'b0, A} + {1'b0, b_op}
                         + {{WIDTH{1'b0}}, sub};

    // Signed overflow: operand signs agree but the sum sign differs.
    assign sum_ov = (A[WIDTH-1] == b_op[WIDTH-1])
                 && (sum[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        cout_d   = 1'b0;
        case (cntrl)
            OP_PASS: result_d = B;
            OP_ADD, OP_SUB: begin
                result_d = sum;
                ovf_d    = sum_ov;
                cout_d   = sum_co;
            end
            OP_AND:  result_d = A & B;
            OP_OR:   result_d = A | B;
            OP_XOR:  result_d = A ^ B;
            default: result_d = '0;
        endcase
        neg_d  = result_d[WIDTH-1];
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
        end
    end

    assign result    = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_alu_64.sv
// tb_alu_64: directed vector table, hand sequences for reset/latency,
// and a random sweep per opcode against an independent wide-math model.
module tb_alu_64;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] A, B;
    logic [2:0]  cntrl;
    logic [63:0] result;
    logic        negative, zero, overflow, carry_out;

    int nvec = 0;
    int nerr = 0;

    alu_64 dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .cntrl(cntrl),
        .result(result), .negative(negative), .zero(zero),
        .overflow(overflow), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        n, z, v, c;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAX  = 64'h7FFF_FFFF_FFFF_FFFF;

    task automatic check(input string name, input logic [63:0] er,
                         input logic en, input logic ez,
                         input logic ev, input logic ec);
        nvec++;
        if (result !== er || negative !== en || zero !== ez ||
            overflow !== ev || carry_out !== ec) begin
            nerr++;
            $display("FAIL %s: got res=%h n%b z%b v%b c%b want res=%h n%b z%b v%b c%b",
                     name, result, negative, zero, overflow, carry_out,
                     er, en, ez, ev, ec);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b);
        cntrl = op;
        A     = a;
        B     = b;
    endtask

    // Sample 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] r,
                         output logic n, output logic z,
                         output logic v, output logic c);
        logic signed [65:0] s;
        logic        [64:0] u;
        r = '0; v = 1'b0; c = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                u = {1'b0, a} + {1'b0, b};
                r = u[63:0];
                c = u[64];
                s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
                v = (s > $signed(66'(MAX))) || (s < -$signed(66'(MIN)));
            end
            3'b011: begin
                r = a - b;
                c = (a >= b);
                s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
                v = (s > $signed(66'(MAX))) || (s < -$signed(66'(MIN)));
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = '0;
        endcase
        n = r[63];
        z = (r == 64'd0);
    endtask

    initial begin
        logic [63:0] er;
        logic        en, ez, ev, ec;

        //            op      a             b        res          n  z  v  c
        vecs[0]  = '{3'b010, 64'd1,        64'd1,   64'd2,       0, 0, 0, 0};
        vecs[1]  = '{3'b010, MAX,          64'd1,   MIN,         1, 0, 1, 0};
        vecs[2]  = '{3'b011, 64'd5,        64'd3,   64'd2,       0, 0, 0, 1};
        vecs[3]  = '{3'b011, 64'd0,        64'd1,   ONES,        1, 0, 0, 0};
        vecs[4]  = '{3'b011, 64'h1234,     64'h1234, 64'd0,      0, 1, 0, 1};
        vecs[5]  = '{3'b011, MIN,          64'd1,   MAX,         0, 0, 1, 1};
        vecs[6]  = '{3'b100, 64'hF0F0,     64'hFF00, 64'hF000,   0, 0, 0, 0};
        vecs[7]  = '{3'b101, 64'hF0F0,     64'hFF00, 64'hFFF0,   0, 0, 0, 0};
        vecs[8]  = '{3'b110, 64'hF0F0,     64'hFF00, 64'h0FF0,   0, 0, 0, 0};
        vecs[9]  = '{3'b000, 64'hF0F0,     MIN,     MIN,         1, 0, 0, 0};
        vecs[10] = '{3'b111, ONES,         ONES,    64'd0,       0, 1, 0, 0};
        vecs[11] = '{3'b001, 64'd5,        64'd7,   64'd0,       0, 1, 0, 0};
        vecs[12] = '{3'b010, ONES,         ONES,    64'hFFFF_FFFF_FFFF_FFFE,
                     1, 0, 0, 1};
        vecs[13] = '{3'b010, MIN,          MIN,     64'd0,       0, 1, 1, 1};
        vecs[14] = '{3'b011, MAX,          ONES,    MIN,         1, 0, 1, 0};
        vecs[15] = '{3'b110, ONES,         ONES,    64'd0,       0, 1, 0, 0};

        // Reset with A=B=ones, add pending: outputs clear.
        reset = 1'b1;
        drive(3'b010, ONES, ONES);
        #2;
        check("reset_hold", 64'd0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("first_after_reset", 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 1);

        // Async reset must clear without a clock edge.
        reset = 1'b1;
        #2;
        check("async_reset", 64'd0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            check($sformatf("vec%0d", i), vecs[i].res, vecs[i].n,
                  vecs[i].z, vecs[i].v, vecs[i].c);
        end

        // Back-to-back: output must hold until the next edge.
        drive(3'b010, 64'd10, 64'd20);
        tick();
        check("b2b_1", 64'd30, 0, 0, 0, 0);
        drive(3'b011, 64'd3, 64'd5);
        #2;
        check("b2b_hold", 64'd30, 0, 0, 0, 0);
        tick();
        check("b2b_2", 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0);
        drive(3'b111, 64'd9, 64'd9);
        tick();
        check("b2b_3", 64'd0, 0, 1, 0, 0);

        // Reset mid-stream discards the in-flight op.
        drive(3'b101, 64'hAA, 64'h55);
        #2;
        reset = 1'b1;
        tick();
        check("mid_reset", 64'd0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_idle", 64'd0, 0, 0, 0, 0);
        tick();
        check("post_reset_op", 64'hFF, 0, 0, 0, 0);

        // Random sweep per opcode.
        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 100; k++) begin
                logic [63:0] ra, rb;
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (k == 0) rb = ra;
                drive(op[2:0], ra, rb);
                model(op[2:0], ra, rb, er, en, ez, ev, ec);
                tick();
                check($sformatf("rand_op%0d_%0d", op, k), er, en, ez, ev, ec);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_64.md
Name: alu_64

Overview:
- 64-bit integer ALU for the datapath execute stage.
- Performs pass-B, add, subtract, AND, OR and XOR, and produces negative, zero, overflow and carry_out flags.
- Operands and opcode are sampled combinationally; result and flags are registered.
- One clock; asynchronous active-high reset.

Parameters:
- WIDTH, 64, operand/result width in bits. The design is verified only at 64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all outputs
- A  input  64  operand A
- B  input  64  operand B
- cntrl  input  3  operation select
- result  output  64  registered operation result
- negative  output  1  registered; equals result[63]
- zero  output  1  registered; 1 when result is all zeros
- overflow  output  1  registered; signed overflow on add/sub
- carry_out  output  1  registered; carry out of bit 63 on add/sub

Behaviour:
- Reset: while reset=1, asynchronously force result=0, negative=0, zero=0, overflow=0, carry_out=0. First update occurs at the first rising clk edge after reset deasserts.
- Latency: exactly 1 cycle. Outputs at edge N+1 reflect A, B and cntrl present just before edge N+1. No handshake; a new operation can be issued every cycle.
- cntrl encoding:
  - 000 result = B
  - 010 result = A + B
  - 011 result = A - B
  - 100 result = A & B
  - 101 result = A | B
  - 110 result = A ^ B
  - 001, 111 (reserved) result = 0
- Add/sub datapath: one 64-bit adder computes A + (B ^ {64{sub}}) + sub, where sub = 1 for 011.
  - carry_out = carry out of bit 63. For subtract, 1 means no borrow (A >= B unsigned).
  - overflow = carry into bit 63 XOR carry out of bit 63. Equivalently, both operand signs match (after B inversion) and the sum sign differs.
- Sum arithmetic is modulo 2^64; wrap-around is not an error and only sets the flags.
- Non-arithmetic codes (000, 100, 101, 110, reserved): overflow=0 and carry_out=0.
- negative and zero are derived from the final result for every code, including reserved codes (reserved gives zero=1, negative=0).
- Flags and result update in the same cycle; they are never mixed from different operations.
- Reset asserted mid-stream discards the in-flight result. There is no stored state other than the output registers.
- Simultaneous change of cntrl and operands is legal; only values at the clock edge matter.

Test Plan:
- Reset: assert reset with A=B=all-ones, cntrl=010 -> all outputs 0 immediately, without waiting for a clock. Deassert, clock once -> result=0xFFFF_FFFF_FFFF_FFFE, carry_out=1, overflow=0, negative=1.
- Add: A=1, B=1, cntrl=010 -> result=2, carry_out=0, overflow=0, negative=0, zero=0. A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> result=0x8000_0000_0000_0000, overflow=1, negative=1, carry_out=0.
- Subtract:
  - A=5, B=3, cntrl=011 -> result=2, carry_out=1, overflow=0.
  - A=0, B=1 -> result=0xFFFF_FFFF_FFFF_FFFF, negative=1, carry_out=0.
  - A=B=0x1234 -> result=0, zero=1, carry_out=1.
  - A=0x8000_0000_0000_0000, B=1 -> overflow=1.
- Logic and pass:
  - A=0xF0F0, B=0xFF00: cntrl=100 -> 0xF000; 101 -> 0xFFF0; 110 -> 0x0FF0.
  - cntrl=000 with B=0x8000_0000_0000_0000 -> result=B, negative=1, overflow=0, carry_out=0.
- Reserved/latency: cntrl=111 with any A, B -> result=0, zero=1. Back-to-back ops on consecutive cycles -> each result appears exactly one edge after its inputs.
- Randomized: 100+ random A/B per opcode, checked against a reference model including all four flags.
